// File: rtl/alu_seq_pkg.sv
// alu_seq_pkg: op/state encodings, ALU control constants and flag helper for alu_seq.
package alu_seq_pkg;
    typedef enum logic [2:0] {
        OP_ADD = 3'd0, OP_ADC = 3'd1, OP_SUB = 3'd2, OP_SBC = 3'd3,
        OP_AND = 3'd4, OP_XOR = 3'd5, OP_OR = 3'd6, OP_CP = 3'd7
    } alu_op_t;

    typedef enum logic [2:0] {S_IDLE, S_LA, S_LO, S_HI, S_DONE} state_t;

    localparam logic SH_OE  = 1'b0;
    localparam logic RES_OE = 1'b1;
    localparam logic BUS_LD = 1'b1;
    localparam logic NO_LD  = 1'b0;

    localparam int FLAG_Z = 3;
    localparam int FLAG_N = 2;
    localparam int FLAG_H = 1;
    localparam int FLAG_C = 0;

    // {r,s,v,ne} indexed by alu_op_t
    localparam logic [3:0] ALU_FN [8] = '{
        4'b0010, 4'b0010, 4'b0011, 4'b0011,
        4'b0100, 4'b1001, 4'b1000, 4'b0011
    };

    function automatic logic is_sub(alu_op_t op);
        return op inside {OP_SUB, OP_SBC, OP_CP};
    endfunction

    function automatic logic lo_cin(alu_op_t op, logic cin);
        return op == OP_ADD ? 1'b0 : op == OP_ADC ? cin : op == OP_SBC ? ~cin : 1'b1;
    endfunction

    // The ALU reports not-borrow on subtracts, so H/C are inverted for those ops.
    function automatic logic [3:0] alu_seq_flags(alu_op_t op, logic [7:0] res, logic lc, logic hc);
        logic [3:0] f;
        logic lop;
        lop       = op inside {OP_AND, OP_XOR, OP_OR};
        f         = '0;
        f[FLAG_Z] = res == 8'h00;
        f[FLAG_N] = is_sub(op);
        f[FLAG_H] = lop ? op == OP_AND : lc ^ is_sub(op);
        f[FLAG_C] = lop ? 1'b0 : hc ^ is_sub(op);
        return f;
    endfunction
endpackage

// File: rtl/alu_seq.sv
// alu_seq: 3-cycle micro-sequencer driving the nibble-serial ALU, returning result and {Z,N,H,C}.
// ALU_SEQ_CP_EN: when defined, op 7 (CP) suppresses the result write (out_we=0).
module alu_seq
    import alu_seq_pkg::*;
(
    input  logic       clk,
    input  logic       nreset,
    input  logic       req_valid,
    output logic       req_ready,
    input  logic [2:0] req_op,
    input  logic [7:0] req_a,
    input  logic [7:0] req_b,
    input  logic       req_cin,
    output logic [7:0] alu_bus,
    output logic       alu_la,
    output logic       alu_lb,
    output logic       alu_oe,
    output logic [3:0] alu_fn,
    output logic       alu_ci,
    output logic       alu_l,
    output logic       alu_h,
    input  logic [7:0] alu_result,
    input  logic       alu_carry,
    output logic       out_valid,
    input  logic       out_ready,
    output logic [7:0] out_result,
    output logic [3:0] out_flags,
    output logic       out_we
);
    state_t     state_q, state_d;
    alu_op_t    op_q, op_d;
    logic [7:0] b_q, b_d, bus_q, bus_d, res_q, res_d;
    logic [3:0] fn_q, fn_d, flags_q, flags_d;
    logic       cin_q, cin_d, la_q, la_d, lb_q, lb_d, oe_q, oe_d, ci_q, ci_d;
    logic       l_q, l_d, h_q, h_d, ov_q, ov_d, we_q, we_d, we_hi;

`ifdef ALU_SEQ_CP_EN
    assign we_hi = op_q != OP_CP;
`else
    assign we_hi = 1'b1;
`endif

    // During HI, ci_q still holds the LO nibble carry, which doubles as the H source.
    always_comb begin
        state_d = state_q;
        op_d    = op_q;
        b_d     = b_q;
        cin_d   = cin_q;
        bus_d   = '0;
        la_d    = NO_LD;
        lb_d    = NO_LD;
        oe_d    = SH_OE;
        fn_d    = '0;
        ci_d    = 1'b0;
        l_d     = 1'b0;
        h_d     = 1'b0;
        ov_d    = ov_q;
        res_d   = res_q;
        flags_d = flags_q;
        we_d    = we_q;
        case (state_q)
            S_IDLE: if (req_valid) begin
                state_d = S_LA;
                op_d    = alu_op_t'(req_op);
                b_d     = req_b;
                cin_d   = req_cin;
                bus_d   = req_a;
                la_d    = BUS_LD;
            end
            S_LA: begin
                state_d = S_LO;
                bus_d   = b_q;
                lb_d    = BUS_LD;
                l_d     = 1'b1;
                fn_d    = ALU_FN[op_q];
                ci_d    = lo_cin(op_q, cin_q);
            end
            S_LO: begin
                state_d = S_HI;
                h_d     = 1'b1;
                oe_d    = RES_OE;
                fn_d    = ALU_FN[op_q];
                ci_d    = alu_carry;
            end
            S_HI: begin
                state_d = S_DONE;
                ov_d    = 1'b1;
                res_d   = alu_result;
                flags_d = alu_seq_flags(op_q, alu_result, ci_q, alu_carry);
                we_d    = we_hi;
            end
            S_DONE: if (out_ready) begin
                state_d = S_IDLE;
                ov_d    = 1'b0;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge nreset) begin
        if (!nreset) begin
            state_q <= S_IDLE;
            op_q    <= OP_ADD;
            b_q     <= '0;
            cin_q   <= 1'b0;
            bus_q   <= '0;
            la_q    <= NO_LD;
            lb_q    <= NO_LD;
            oe_q    <= SH_OE;
            fn_q    <= '0;
            ci_q    <= 1'b0;
            l_q     <= 1'b0;
            h_q     <= 1'b0;
            ov_q    <= 1'b0;
            res_q   <= '0;
            flags_q <= '0;
            we_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            op_q    <= op_d;
            b_q     <= b_d;
            cin_q   <= cin_d;
            bus_q   <= bus_d;
            la_q    <= la_d;
            lb_q    <= lb_d;
            oe_q    <= oe_d;
            fn_q    <= fn_d;
            ci_q    <= ci_d;
            l_q     <= l_d;
            h_q     <= h_d;
            ov_q    <= ov_d;
            res_q   <= res_d;
            flags_q <= flags_d;
            we_q    <= we_d;
        end
    end

    assign req_ready  = state_q == S_IDLE;
    assign alu_bus    = bus_q;
    assign alu_la     = la_q;
    assign alu_lb     = lb_q;
    assign alu_oe     = oe_q;
    assign alu_fn     = fn_q;
    assign alu_ci     = ci_q;
    assign alu_l      = l_q;
    assign alu_h      = h_q;
    assign out_valid  = ov_q;
    assign out_result = res_q;
    assign out_flags  = flags_q;
    assign out_we     = we_q;
endmodule
